// File: rtl/irq_pend_ctrl.sv
// Interrupt front end: synchronises req_in, latches rising edges into pending, and runs
// the irq / irq_ack / eoi handshake around an external 4-to-2 priority encoder.
// Optional REQ-state timeout abort is enabled by defining IRQ_TIMEOUT_EN.
module irq_pend_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  output logic [3:0] pend_out,
  input  logic [1:0] enc_a,
  input  logic       enc_v,
  output logic       irq,
  output logic [1:0] irq_id,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       in_service,
  output logic [3:0] pending,
  output logic       err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("irq_pend_ctrl: illegal parameter value");
  end

  state_t                        state, state_nxt;
  logic [SYNC_STAGES-1:0][3:0]   sync_q;
  logic [3:0]                    hist;
  logic [3:0]                    rise;
  logic [3:0]                    clr_vec;
  logic                          irq_nxt;
  logic [1:0]                    id_nxt;
  logic                          svc_nxt;
  logic                          expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist   <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_q[SYNC_STAGES-1] & ~hist;
  assign pend_out = pending & ~mask;

  // A new edge wins over the acknowledge clear of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_vec) | rise;
  end

`ifdef IRQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            tmo_cnt <= '0;
    else if (state != REQ) tmo_cnt <= '0;
    else                   tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign expired = (state == REQ) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err_timeout <= 1'b0;
    else if (expired && !irq_ack) err_timeout <= 1'b1;
  end
`else
  assign expired     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= 2'd0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nxt;
      irq        <= irq_nxt;
      irq_id     <= id_nxt;
      in_service <= svc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq;
    id_nxt    = irq_id;
    svc_nxt   = in_service;
    clr_vec   = '0;
    case (state)
      IDLE: begin
        if (enc_v) begin
          id_nxt    = enc_a;
          irq_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr_vec[irq_id] = 1'b1;
          irq_nxt         = 1'b0;
          svc_nxt         = 1'b1;
          state_nxt       = SERVICE;
        end else if (expired) begin
          irq_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          svc_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
